// File: rtl/l1_ahb_mtx_rr_arb.sv
// l1_ahb_mtx_rr_arb: two-port round-robin address-phase arbiter for one bus-matrix output stage.
// Define L1AHBMTX_BURST_HOLD_EN to keep fixed-length bursts on one port.
module l1_ahb_mtx_rr_arb #(
    parameter logic RR_INIT = 1'b1
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       req_port0,
    input  logic       req_port1,
    input  logic       HREADYM,
    input  logic       HSELM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    input  logic       HMASTLOCKM,
    output logic       addr_in_port,
    output logic       no_port
);

    logic addr_in_port_q, addr_in_port_d;
    logic no_port_q, no_port_d;
    logic last_port_q, last_port_d;
    logic burst_active, hold, arb, any_req, grant;

`ifdef L1AHBMTX_BURST_HOLD_EN
    logic [3:0] cnt_q, cnt_d, beats;
    logic       accept;
    logic       unused_burst0;

    assign unused_burst0 = HBURSTM[0];

    // Hold on the post-beat count so the NONSEQ itself is protected and the last SEQ re-arbitrates.
    always_comb begin
        accept = HREADYM & HSELM & HTRANSM[1];
        beats = (HBURSTM[2:1] == 2'b11) ? 4'd15 :
                (HBURSTM[2:1] == 2'b10) ? 4'd7  :
                (HBURSTM[2:1] == 2'b01) ? 4'd3  : 4'd0;
        cnt_d = !HREADYM                             ? cnt_q :
                (accept && !HTRANSM[0])              ? beats :
                !HTRANSM[0]                          ? 4'd0  :
                (accept && cnt_q != 4'd0)            ? cnt_q - 4'd1 : cnt_q;
        burst_active = (cnt_d != 4'd0);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) cnt_q <= 4'd0;
        else          cnt_q <= cnt_d;
    end
`else
    logic unused_bus;

    assign unused_bus   = ^{HSELM, HTRANSM, HBURSTM};
    assign burst_active = 1'b0;
`endif

    always_comb begin
        hold           = HMASTLOCKM | burst_active;
        arb            = HREADYM & ~hold;
        any_req        = req_port0 | req_port1;
        grant          = (req_port0 & req_port1) ? ~last_port_q : req_port1;
        addr_in_port_d = (arb && any_req) ? grant : addr_in_port_q;
        last_port_d    = (arb && any_req) ? grant : last_port_q;
        no_port_d      = arb ? ~any_req : no_port_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_in_port_q <= 1'b0;
            no_port_q      <= 1'b1;
            last_port_q    <= RR_INIT;
        end else begin
            addr_in_port_q <= addr_in_port_d;
            no_port_q      <= no_port_d;
            last_port_q    <= last_port_d;
        end
    end

    assign addr_in_port = addr_in_port_q;
    assign no_port      = no_port_q;

endmodule

// File: tb/tb_l1_ahb_mtx_rr_arb.sv
// tb_l1_ahb_mtx_rr_arb: vector-table bench for the round-robin arbiter, expected grants queued per cycle.
module tb_l1_ahb_mtx_rr_arb;

    localparam logic [1:0] I = 2'b00, BY = 2'b01, NS = 2'b10, SQ = 2'b11;
`ifdef L1AHBMTX_BURST_HOLD_EN
    localparam bit BH = 1'b1;
`else
    localparam bit BH = 1'b0;
`endif

    typedef struct {
        logic       r0, r1, rdy, lk;
        logic [1:0] tr;
        logic [2:0] bu;
        logic       ep, en;
        int         id;
    } vec_t;

    logic       HCLK = 1'b0, HRESETn = 1'b0;
    logic       req_port0 = 1'b0, req_port1 = 1'b0, HREADYM = 1'b1, HSELM = 1'b1, HMASTLOCKM = 1'b0;
    logic [1:0] HTRANSM = 2'b00;
    logic [2:0] HBURSTM = 3'b000;
    logic       addr_in_port, no_port;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0, failures = 0, next_id = 0;

    l1_ahb_mtx_rr_arb dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .req_port0(req_port0), .req_port1(req_port1),
        .HREADYM(HREADYM), .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM),
        .HMASTLOCKM(HMASTLOCKM), .addr_in_port(addr_in_port), .no_port(no_port)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string nm, input int id, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec%0d actual=%0b expected=%0b", nm, id, act, exp);
        end
    endtask

    task automatic add(input logic r0, r1, rdy, lk, input logic [1:0] tr, input logic [2:0] bu,
                       input logic ep, en);
        vec_t v;
        v = '{r0: r0, r1: r1, rdy: rdy, lk: lk, tr: tr, bu: bu, ep: ep, en: en, id: next_id};
        next_id++;
        vecs.push_back(v);
    endtask

    task automatic run();
        vec_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            req_port0  = vecs[i].r0;
            req_port1  = vecs[i].r1;
            HREADYM    = vecs[i].rdy;
            HMASTLOCKM = vecs[i].lk;
            HTRANSM    = vecs[i].tr;
            HBURSTM    = vecs[i].bu;
            sb.push_back(vecs[i]);
            @(posedge HCLK);
            #1;
            e = sb.pop_front();
            chk("addr_in_port", e.id, addr_in_port, e.ep);
            chk("no_port", e.id, no_port, e.en);
        end
        vecs.delete();
    endtask

    initial begin
        repeat (2) @(posedge HCLK);
        #1;
        chk("reset_addr_in_port", -1, addr_in_port, 1'b0);
        chk("reset_no_port", -1, no_port, 1'b1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int i = 0; i < 10; i++) add(0, 0, 1, 0, I, 3'b000, 0, 1);
        add(0, 1, 1, 0, I, 3'b000, 1, 0);
        add(0, 0, 1, 0, I, 3'b000, 1, 1);
        add(1, 1, 1, 0, I, 3'b000, 0, 0);
        add(1, 1, 1, 0, I, 3'b000, 1, 0);
        add(1, 1, 1, 0, I, 3'b000, 0, 0);
        add(1, 1, 1, 0, I, 3'b000, 1, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 0, 0, I, 3'b000, 1, 0);
        add(1, 1, 1, 0, I, 3'b000, 0, 0);
        add(1, 1, 1, 0, I, 3'b000, 1, 0);
        add(1, 1, 1, 0, I, 3'b000, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 1, 1, 1, I, 3'b000, 0, 0);
        add(1, 1, 1, 0, I, 3'b000, 1, 0);
        add(0, 0, 1, 1, I, 3'b000, 1, 0);
        add(0, 0, 1, 0, I, 3'b000, 1, 1);
        // INCR8 from port 0 with one BUSY while port 1 waits
        add(1, 0, 1, 0, I, 3'b000, 0, 0);
        add(1, 1, 1, 0, NS, 3'b101, BH ? 1'b0 : 1'b1, 0);
        add(1, 1, 1, 0, SQ, 3'b101, 0, 0);
        add(1, 1, 1, 0, SQ, 3'b101, BH ? 1'b0 : 1'b1, 0);
        add(1, 1, 1, 0, SQ, 3'b101, 0, 0);
        add(1, 1, 1, 0, BY, 3'b101, BH ? 1'b0 : 1'b1, 0);
        add(1, 1, 1, 0, SQ, 3'b101, 0, 0);
        add(1, 1, 1, 0, SQ, 3'b101, BH ? 1'b0 : 1'b1, 0);
        add(1, 1, 1, 0, SQ, 3'b101, 0, 0);
        add(1, 1, 1, 0, SQ, 3'b101, 1, 0);
        add(0, 0, 1, 0, I, 3'b000, 1, 1);
        // WRAP4 cut short by IDLE, with a wait state in the middle
        add(1, 0, 1, 0, I, 3'b000, 0, 0);
        add(1, 1, 1, 0, NS, 3'b010, BH ? 1'b0 : 1'b1, 0);
        add(1, 1, 0, 0, SQ, 3'b010, BH ? 1'b0 : 1'b1, 0);
        add(1, 1, 1, 0, SQ, 3'b010, 0, 0);
        add(1, 1, 1, 0, I, 3'b010, 1, 0);
        add(1, 0, 1, 0, I, 3'b000, 0, 0);
        add(1, 1, 1, 0, NS, 3'b111, BH ? 1'b0 : 1'b1, 0);
        run();
        #2 HRESETn = 1'b0;
        #1;
        chk("async_reset_addr_in_port", -2, addr_in_port, 1'b0);
        chk("async_reset_no_port", -2, no_port, 1'b1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        add(1, 1, 1, 0, SQ, 3'b111, 0, 0);
        add(1, 1, 1, 0, SQ, 3'b111, 1, 0);
        run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1_ahb_mtx_rr_arb.md
# l1_ahb_mtx_rr_arb

Two-port round-robin arbiter for one bus-matrix output stage. It decides which input port drives the shared slave's address phase. It tracks locked sequences and, optionally, fixed-length bursts so a grant is never switched mid-sequence. Its registered port select and no-port flag steer the output stage's address mux and its data-phase port register.

## Interface
- RR_INIT, default 1'b1: last-served port loaded at reset. With the default, port 0 wins the first tie.
- HCLK  input  1  AHB clock
- HRESETn  input  1  reset, asynchronous, active-low
- req_port0  input  1  port 0 request (held transfer & HSEL)
- req_port1  input  1  port 1 request
- HREADYM  input  1  muxed HREADY of the output port
- HSELM  input  1  HSEL currently driven to the slave
- HTRANSM  input  2  HTRANS currently driven (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- HBURSTM  input  3  HBURST currently driven
- HMASTLOCKM  input  1  lock, pre-masked by the output stage's hsel_lock/HSEL
- addr_in_port  output  1  granted port, registered
- no_port  output  1  1 = no port granted (output stage drives zeros), registered

## Operation
- Accepted beat: HREADYM & HSELM & HTRANSM[1].
- Arbitration point: any cycle with HREADYM=1 and hold=0. Outputs and state change only at arbitration points.
- hold = HMASTLOCKM | burst_active. burst_active exists only with the macro; see Configuration.
- Decision at an arbitration point:
  - Neither port requests: no_port←1; addr_in_port retains its value.
  - Exactly one port requests: grant that port; no_port←0.
  - Both ports request: grant the port ≠ last_port (round-robin). This holds even if the currently granted port still requests.
- last_port register: reset to RR_INIT. Updated to the granted port whenever a grant is issued with no_port←0.
- Locked sequence: the grant is frozen while HMASTLOCKM=1. Release happens at the first HREADYM=1 cycle with HMASTLOCKM=0.
- While hold=1, requests are ignored. Both outputs stay constant.
- HREADYM=0 freezes all state, including last_port and the burst counter.
- Reset, asynchronous, including mid-transfer:
  - addr_in_port=0, no_port=1
  - last_port=RR_INIT
  - burst counter=0
  - First grant is possible on the first rising HCLK edge after release.

## Timing
- Request to grant latency: 1 cycle. A request sampled at an arbitration point appears on addr_in_port/no_port after the next HCLK edge.
- Outputs are purely registered. There is no combinational path from req_port* to the outputs.
- A grant change never occurs while HREADYM=0. This guarantees the output stage's data_in_port captures a stable port.
- Back-to-back alternation: with both ports requesting continuously and no hold, the grant toggles on every HREADYM=1 cycle.

## Configuration
- Macro L1AHBMTX_BURST_HOLD_EN.
- Defined: adds a 4-bit beat counter that keeps fixed-length bursts unbroken.
  - On an accepted NONSEQ, the counter loads from HBURSTM: INCR4/WRAP4→3, INCR8/WRAP8→7, INCR16/WRAP16→15, SINGLE/INCR→0.
  - Each accepted SEQ decrements the counter. BUSY (01) does not decrement.
  - burst_active = (counter≠0).
  - An HTRANSM=IDLE or NONSEQ while the counter≠0 (early termination after an ERROR) clears the counter. A NONSEQ then reloads it.
  - The counter saturates at 0 and never wraps.
  - Undefined-length INCR is never held.
- Undefined: no counter; burst_active=0. The grant may switch on any HREADYM=1 cycle outside a lock. Broken bursts are re-issued by the input stage as NONSEQ.

## Test plan
- Reset idle: HRESETn low, then high with no requests → addr_in_port=0 and no_port=1 for 10 cycles. Assert HRESETn mid-grant → outputs return to 0/1 immediately, without waiting for a clock edge.
- Single requester: req_port1=1 with HREADYM=1 → one cycle later addr_in_port=1, no_port=0. Drop req_port1 → one cycle later no_port=1, addr_in_port stays 1.
- Round-robin: both ports request continuously, HREADYM=1, no lock → grants follow 0,1,0,1… (RR_INIT=1). Hold HREADYM=0 for 3 cycles → grant frozen and order resumes unchanged.
- Lock: port 0 granted with HMASTLOCKM=1 for 5 beats while req_port1=1 → addr_in_port stays 0. After HMASTLOCKM falls with HREADYM=1 → grant moves to port 1 one cycle later.
- Burst hold (macro defined): port 0 issues INCR8 (NONSEQ+7 SEQ, with one BUSY inserted) while req_port1=1 → grant held for all 9 address cycles, then switches to 1. With the macro undefined → grant switches after the NONSEQ.
- Early termination (macro defined): port 0 issues WRAP4, then IDLE after 2 beats → counter cleared, and the grant moves to the requesting port 1 on the next HREADYM=1 cycle.
